// File: rtl/axis_video_if.sv
// -----------------------------------------------------------------------------
// axis_video_if
//   AXI4-Stream video bundle: valid/ready handshake, pixel data, start-of-frame
//   (tuser) and end-of-line (tlast).
//   Parameters : TDATA_WIDTH - data width in bits (multiple of 32)
//   Modports   : master - stream source (drives tvalid/tdata/tuser/tlast)
//                slave  - stream sink   (drives tready)
// -----------------------------------------------------------------------------
interface axis_video_if #(
    parameter int TDATA_WIDTH = 64
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tuser;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tuser, input  tlast, output tready);
endinterface

// File: rtl/axis_video_frame_checker.sv
// -----------------------------------------------------------------------------
// axis_video_frame_checker
//   Sink/monitor for an AXI4-Stream video output. Checks frame structure
//   (SOF on tuser, EOL on tlast) against the configured geometry, accumulates
//   a 32-bit per-frame checksum (sum of all 32-bit slices of tdata) and keeps
//   sticky error flags plus a wrapping frame counter.
//
//   Optional feature macro: AXIS_CHECKER_BACKPRESSURE_EN
//     defined     : s_axis.tready = cfg_enable & lfsr[0], 16-bit Fibonacci LFSR
//                   (taps 16,14,13,11, seed 16'hACE1) stepping every cycle.
//     not defined : s_axis.tready = cfg_enable registered once.
//
//   Ports
//     sclk, srst            clock, synchronous active-high reset
//     cfg_enable            1 = accept and check the stream
//     cfg_beats_per_line    expected beats per line   (sampled at frame start)
//     cfg_lines_per_frame   expected lines per frame  (sampled at frame start)
//     err_clr               pulse, clears sticky error flags
//     s_axis                stream input (slave modport)
//     frame_done            1-cycle pulse, frame completed
//     frame_count           completed frames, wraps
//     stat_checksum         checksum of last completed frame
//     err_sof               sticky: data outside frame or SOF inside frame
//     err_line_len          sticky: beat count at tlast != cfg_beats_per_line
//     err_frame_len         sticky: SOF arrived before frame completed
// -----------------------------------------------------------------------------
module axis_video_frame_checker #(
    parameter int TDATA_WIDTH = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 sclk,
    input  logic                 srst,
    input  logic                 cfg_enable,
    input  logic [CNT_WIDTH-1:0] cfg_beats_per_line,
    input  logic [CNT_WIDTH-1:0] cfg_lines_per_frame,
    input  logic                 err_clr,
    axis_video_if.slave          s_axis,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [31:0]          stat_checksum,
    output logic                 err_sof,
    output logic                 err_line_len,
    output logic                 err_frame_len
);

    localparam int N_SLICES = TDATA_WIDTH / 32;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;     // current line number, 1-based
    logic [CNT_WIDTH-1:0] cfg_beats_q, cfg_beats_d;
    logic [CNT_WIDTH-1:0] cfg_lines_q, cfg_lines_d;
    logic [31:0]          checksum_q, checksum_d;
    logic                 frame_done_q, frame_done_d;
    logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
    logic [31:0]          stat_checksum_q, stat_checksum_d;
    logic                 err_sof_q, err_sof_d;
    logic                 err_line_len_q, err_line_len_d;
    logic                 err_frame_len_q, err_frame_len_d;

    logic                 beat_acc;
    logic [31:0]          beat_sum;
    logic [31:0]          run_sum;
    logic [CNT_WIDTH-1:0] beat_num, line_num, beats_eff, lines_eff;
    logic                 new_err_sof, new_err_line, new_err_frame;

    // ---------------------------------------------------------------- tready
`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge sclk) begin
        if (srst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end

    assign s_axis.tready = cfg_enable & lfsr_q[0];
`else
    logic tready_q, tready_d;

    always_comb begin
        tready_d = cfg_enable;
    end

    always_ff @(posedge sclk) begin
        if (srst) tready_q <= 1'b0;
        else      tready_q <= tready_d;
    end

    assign s_axis.tready = tready_q;
`endif

    assign beat_acc = s_axis.tvalid & s_axis.tready;

    // Sum of all 32-bit slices of the current beat, modulo 2^32.
    // NOTE: blocking '=' is correct inside always_comb; the loop accumulates
    // through the variable within one evaluation and no flop is inferred
    // because beat_sum gets a value on every path.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            beat_sum = beat_sum + s_axis.tdata[i*32 +: 32];
        end
    end

    // A beat with tuser starts (or restarts) a frame: it is beat 1 of line 1,
    // seeds the checksum and uses the live cfg values rather than the latched ones.
    always_comb begin
        run_sum   = (s_axis.tuser ? 32'd0 : checksum_q) + beat_sum;
        beat_num  = s_axis.tuser ? CNT_WIDTH'(1)
                  : (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_WIDTH'(1);
        line_num  = s_axis.tuser ? CNT_WIDTH'(1) : line_cnt_q;
        beats_eff = s_axis.tuser ? cfg_beats_per_line  : cfg_beats_q;
        lines_eff = s_axis.tuser ? cfg_lines_per_frame : cfg_lines_q;
    end

    // ------------------------------------------------ next state / outputs
    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        line_cnt_d      = line_cnt_q;
        cfg_beats_d     = cfg_beats_q;
        cfg_lines_d     = cfg_lines_q;
        checksum_d      = checksum_q;
        frame_done_d    = 1'b0;
        frame_count_d   = frame_count_q;
        stat_checksum_d = stat_checksum_q;
        new_err_sof     = 1'b0;
        new_err_line    = 1'b0;
        new_err_frame   = 1'b0;

        if (!cfg_enable) begin
            // Disabling abandons any partial frame; a beat accepted in this
            // cycle (tready is still high) is dropped without checking.
            state_d    = IDLE;
            beat_cnt_d = '0;
            line_cnt_d = '0;
            checksum_d = '0;
        end else if (beat_acc) begin
            if (state_q == IDLE && !s_axis.tuser) begin
                new_err_sof = 1'b1;
            end else begin
                if (state_q == IN_FRAME && s_axis.tuser) begin
                    new_err_sof   = 1'b1;
                    new_err_frame = 1'b1;
                end
                if (s_axis.tuser) begin
                    cfg_beats_d = cfg_beats_per_line;
                    cfg_lines_d = cfg_lines_per_frame;
                end
                state_d    = IN_FRAME;
                checksum_d = run_sum;
                if (s_axis.tlast) begin
                    // A saturated count is always treated as a wrong line length.
                    if (beat_num != beats_eff || (&beat_num)) new_err_line = 1'b1;
                    beat_cnt_d = '0;
                    if (line_num == lines_eff) begin
                        state_d         = IDLE;
                        line_cnt_d      = '0;
                        checksum_d      = '0;
                        frame_done_d    = 1'b1;
                        frame_count_d   = frame_count_q + CNT_WIDTH'(1);
                        stat_checksum_d = run_sum;
                    end else begin
                        line_cnt_d = line_num + CNT_WIDTH'(1);
                    end
                end else begin
                    beat_cnt_d = beat_num;
                    line_cnt_d = line_num;
                end
            end
        end

        // A new error in the same cycle as err_clr wins.
        err_sof_d       = (err_sof_q       & ~err_clr) | new_err_sof;
        err_line_len_d  = (err_line_len_q  & ~err_clr) | new_err_line;
        err_frame_len_d = (err_frame_len_q & ~err_clr) | new_err_frame;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values and simulation order between processes cannot matter.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q         <= IDLE;
            beat_cnt_q      <= '0;
            line_cnt_q      <= '0;
            cfg_beats_q     <= '0;
            cfg_lines_q     <= '0;
            checksum_q      <= '0;
            frame_done_q    <= 1'b0;
            frame_count_q   <= '0;
            stat_checksum_q <= '0;
            err_sof_q       <= 1'b0;
            err_line_len_q  <= 1'b0;
            err_frame_len_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            line_cnt_q      <= line_cnt_d;
            cfg_beats_q     <= cfg_beats_d;
            cfg_lines_q     <= cfg_lines_d;
            checksum_q      <= checksum_d;
            frame_done_q    <= frame_done_d;
            frame_count_q   <= frame_count_d;
            stat_checksum_q <= stat_checksum_d;
            err_sof_q       <= err_sof_d;
            err_line_len_q  <= err_line_len_d;
            err_frame_len_q <= err_frame_len_d;
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_count   = frame_count_q;
    assign stat_checksum = stat_checksum_q;
    assign err_sof       = err_sof_q;
    assign err_line_len  = err_line_len_q;
    assign err_frame_len = err_frame_len_q;

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_video_frame_checker
//   Directed self-checking bench for axis_video_frame_checker (default build;
//   the LFSR backpressure section is compiled when AXIS_CHECKER_BACKPRESSURE_EN
//   is defined). Inputs change #1 after the rising edge or at the falling edge;
//   outputs are read #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_axis_video_frame_checker;

    localparam int TDATA_WIDTH = 64;
    localparam int CNT_WIDTH   = 16;
    localparam logic [63:0] D12 = 64'h00000001_00000002;

    logic                 sclk = 1'b0;
    logic                 srst;
    logic                 cfg_enable;
    logic [CNT_WIDTH-1:0] cfg_beats_per_line;
    logic [CNT_WIDTH-1:0] cfg_lines_per_frame;
    logic                 err_clr;
    logic                 frame_done;
    logic [CNT_WIDTH-1:0] frame_count;
    logic [31:0]          stat_checksum;
    logic                 err_sof;
    logic                 err_line_len;
    logic                 err_frame_len;

    int tests_run    = 0;
    int tests_failed = 0;

    axis_video_if #(.TDATA_WIDTH(TDATA_WIDTH)) axis ();

    axis_video_frame_checker #(
        .TDATA_WIDTH(TDATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .sclk               (sclk),
        .srst               (srst),
        .cfg_enable         (cfg_enable),
        .cfg_beats_per_line (cfg_beats_per_line),
        .cfg_lines_per_frame(cfg_lines_per_frame),
        .err_clr            (err_clr),
        .s_axis             (axis),
        .frame_done         (frame_done),
        .frame_count        (frame_count),
        .stat_checksum      (stat_checksum),
        .err_sof            (err_sof),
        .err_line_len       (err_line_len),
        .err_frame_len      (err_frame_len)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [63:0] d, input logic u, input logic l);
        int waited = 0;
        axis.tvalid = 1'b1;
        axis.tdata  = d;
        axis.tuser  = u;
        axis.tlast  = l;
        @(negedge sclk);
        while (!axis.tready && waited < 200) begin
            @(negedge sclk);
            waited++;
        end
        if (!axis.tready) check("tready_wait", 32'(axis.tready), 32'h1);
        @(posedge sclk);
        #1;
        axis.tvalid = 1'b0;
        axis.tuser  = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic send_frame(input int bpl, input int lpf, input logic [63:0] d);
        for (int l = 0; l < lpf; l++)
            for (int b = 0; b < bpl; b++)
                send_beat(d, (l == 0 && b == 0), (b == bpl - 1));
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    task automatic check_no_errors(input string tag);
        check({tag, "_err_sof"},       32'(err_sof),       32'h0);
        check({tag, "_err_line_len"},  32'(err_line_len),  32'h0);
        check({tag, "_err_frame_len"}, 32'(err_frame_len), 32'h0);
    endtask

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_model;
    logic        lfsr_mon_en = 1'b0;

    always @(posedge sclk) begin
        if (srst) lfsr_model <= 16'hACE1;
        else      lfsr_model <= {lfsr_model[14:0],
                                 lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
    end

    always @(negedge sclk) begin
        if (lfsr_mon_en) check("t6_tready_lfsr", 32'(axis.tready), 32'(cfg_enable & lfsr_model[0]));
    end
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst                = 1'b1;
        cfg_enable          = 1'b0;
        err_clr             = 1'b0;
        cfg_beats_per_line  = 16'd4;
        cfg_lines_per_frame = 16'd3;
        axis.tvalid         = 1'b0;
        axis.tdata          = '0;
        axis.tuser          = 1'b0;
        axis.tlast          = 1'b0;
        idle(3);

        // Reset state
        check("rst_frame_done",    32'(frame_done),    32'h0);
        check("rst_frame_count",   32'(frame_count),   32'h0);
        check("rst_stat_checksum", stat_checksum,      32'h0);
        check("rst_tready",        32'(axis.tready),   32'h0);
        check_no_errors("rst");

        srst       = 1'b0;
        cfg_enable = 1'b1;
        idle(1);
`ifndef AXIS_CHECKER_BACKPRESSURE_EN
        check("en_tready", 32'(axis.tready), 32'h1);
`endif

        // T1/T2: 4x3 frame, each beat sums to 3 -> 36
        for (int i = 0; i < 12; i++) begin
            send_beat(D12, (i == 0), (i % 4 == 3));
            if (i == 10) check("t1_no_early_done", 32'(frame_done), 32'h0);
        end
        check("t1_frame_done",  32'(frame_done),  32'h1);
        check("t1_frame_count", 32'(frame_count), 32'h1);
        check("t2_checksum",    stat_checksum,    32'h00000024);
        check_no_errors("t1");
        idle(1);
        check("t1_done_pulse_1cyc", 32'(frame_done), 32'h0);

        // Checksum wrap: sum(0..11)=66 plus 12*0xFFFFFFFF (= -12) -> 54
        for (int i = 0; i < 12; i++) send_beat({32'(i), 32'hFFFF_FFFF}, (i == 0), (i % 4 == 3));
        check("wrap_checksum",    stat_checksum,    32'h00000036);
        check("wrap_frame_count", 32'(frame_count), 32'h2);

        // T3: line 2 carries 5 beats
        for (int l = 0; l < 3; l++) begin
            int len;
            len = (l == 1) ? 5 : 4;
            for (int b = 0; b < len; b++) send_beat(64'h0, (l == 0 && b == 0), (b == len - 1));
            if (l == 0) check("t3_line1_ok",      32'(err_line_len), 32'h0);
            if (l == 1) check("t3_line2_err",     32'(err_line_len), 32'h1);
        end
        check("t3_frame_count", 32'(frame_count), 32'h3);
        check("t3_frame_done",  32'(frame_done),  32'h1);
        pulse_err_clr();
        check("t3_err_clr", 32'(err_line_len), 32'h0);

        // Boundary: 1x1 frame, single beat carries both SOF and EOL
        cfg_beats_per_line  = 16'd1;
        cfg_lines_per_frame = 16'd1;
        send_beat(64'h00000005_00000007, 1'b1, 1'b1);
        check("b1x1_frame_done",  32'(frame_done),  32'h1);
        check("b1x1_frame_count", 32'(frame_count), 32'h4);
        check("b1x1_checksum",    stat_checksum,    32'h0000000C);
        check("b1x1_line_len",    32'(err_line_len), 32'h0);

        // cfg change mid-frame takes effect only on the next frame
        cfg_beats_per_line  = 16'd4;
        cfg_lines_per_frame = 16'd3;
        send_beat(D12, 1'b1, 1'b0);
        cfg_beats_per_line  = 16'd2;
        cfg_lines_per_frame = 16'd2;
        for (int i = 1; i < 12; i++) send_beat(D12, 1'b0, (i % 4 == 3));
        check("cfg_mid_frame_count", 32'(frame_count), 32'h5);
        check_no_errors("cfg_mid");
        cfg_beats_per_line  = 16'd4;
        cfg_lines_per_frame = 16'd3;

        // T4: data outside a frame, error-wins-over-clear, then SOF mid-frame
        send_beat(D12, 1'b0, 1'b0);
        check("t4_err_sof", 32'(err_sof), 32'h1);
        send_beat(D12, 1'b0, 1'b0);
        err_clr = 1'b1;
        send_beat(D12, 1'b0, 1'b0);
        err_clr = 1'b0;
        check("t4_err_wins_clr",   32'(err_sof),     32'h1);
        check("t4_count_unchanged", 32'(frame_count), 32'h5);
        pulse_err_clr();
        check("t4_err_sof_clr", 32'(err_sof), 32'h0);
        for (int i = 0; i < 6; i++) send_beat(D12, (i == 0), (i == 3));
        send_beat(D12, 1'b1, 1'b0);
        check("t4_sof_in_frame",  32'(err_sof),       32'h1);
        check("t4_err_frame_len", 32'(err_frame_len), 32'h1);
        for (int i = 1; i < 12; i++) send_beat(D12, 1'b0, (i % 4 == 3));
        check("t4_restart_count",  32'(frame_count),  32'h6);
        check("t4_restart_cksum",  stat_checksum,     32'h00000024);
        check("t4_no_line_err",    32'(err_line_len), 32'h0);

        // T5: cfg_enable dropped mid-frame, re-enabled, full frame
        pulse_err_clr();
        for (int i = 0; i < 6; i++) send_beat(D12, (i == 0), (i == 3));
        cfg_enable = 1'b0;
`ifndef AXIS_CHECKER_BACKPRESSURE_EN
        check("t5_tready_same_cyc", 32'(axis.tready), 32'h1);
`endif
        idle(1);
        check("t5_tready_dropped", 32'(axis.tready), 32'h0);
        idle(2);
        cfg_enable = 1'b1;
        idle(1);
`ifndef AXIS_CHECKER_BACKPRESSURE_EN
        check("t5_tready_back", 32'(axis.tready), 32'h1);
`endif
        send_frame(4, 3, D12);
        check("t5_frame_count", 32'(frame_count), 32'h7);
        check("t5_checksum",    stat_checksum,    32'h00000024);
        check_no_errors("t5");

        // srst mid-frame: make a sticky error first so reset has work to do
        send_beat(D12, 1'b1, 1'b0);
        send_beat(D12, 1'b1, 1'b0);
        check("t5_pre_rst_err", 32'(err_sof), 32'h1);
        srst = 1'b1;
        idle(1);
        check("t5_rst_frame_count", 32'(frame_count), 32'h0);
        check("t5_rst_checksum",    stat_checksum,    32'h0);
        check("t5_rst_frame_done",  32'(frame_done),  32'h0);
`ifndef AXIS_CHECKER_BACKPRESSURE_EN
        check("t5_rst_tready",      32'(axis.tready), 32'h0);
`endif
        check_no_errors("t5_rst");
        srst = 1'b0;
        idle(1);

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
        // T6: 100 frames of 16x8 under LFSR backpressure
        cfg_beats_per_line  = 16'd16;
        cfg_lines_per_frame = 16'd8;
        lfsr_mon_en = 1'b1;
        for (int f = 0; f < 100; f++) send_frame(16, 8, D12);
        lfsr_mon_en = 1'b0;
        check("t6_frame_count", 32'(frame_count), 32'd100);
        check("t6_checksum",    stat_checksum,    32'd384);
        check_no_errors("t6");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
